// File: rtl/comp_agc_p.sv
// X/Y compressor: magnitude -> gain table -> attack/release smoothing -> serial multiply -> saturate.
// Latency iv->ov GW+5 clocks; one sample in flight, rdy low while busy, iv while busy is dropped and flagged in ovr.
module comp_agc_p #(
    parameter int DW  = 16,
    parameter int MW  = 8,
    parameter int AW  = 7,
    parameter int GW  = 8,
    parameter int GF  = 4,
    parameter int ATK = 2,
    parameter int REL = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] dix_i,
    input  logic [DW-1:0] diy_i,
    input  logic          iv_i,
    output logic          rdy_o,
    output logic [DW-1:0] dox_o,
    output logic [DW-1:0] doy_o,
    output logic          ov_o,
    input  logic [GW-1:0] cin_i,
    input  logic          cwe_i,
    input  logic          byp_i,
    output logic [GW-1:0] gmon_o,
    output logic          ovr_o
);
    localparam int SW    = GW + REL;
    localparam int PW    = DW + GW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(GW + 1);
    localparam logic [GW-1:0] UNITY    = GW'(1) << GF;
    localparam logic [SW-1:0] GS_UNITY = SW'(UNITY) << REL;
    localparam logic signed [PW-1:0] PMAX = (PW'(1) << (DW - 1)) - PW'(1);
    localparam logic signed [PW-1:0] PMIN = ~PMAX;

    typedef enum logic [2:0] {S_IDLE, S_ABS, S_MAG, S_LUT, S_SMO, S_MUL, S_OUT} state_t;

    state_t        state_q;
    logic [DW-1:0] x_q, y_q;
    logic [MW-2:0] a_q, b_q;
    logic [AW-1:0] idx_q;
    logic [GW-1:0] gt_q, gain_q;
    logic          byp_q;
    logic [SW-1:0] gs_q, gs_d, gtx_d;
    logic [PW-1:0] mx_q, my_q, ax_q, ay_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] dox_q, doy_q;
    logic          ov_q, rdy_q, ovr_q;
    logic [GW-1:0] tbl_q [DEPTH];
    logic [MW-2:0] hi_d, lo_d;
    logic [MW-1:0] m_d;
    logic [AW-1:0] idx_d;

    function automatic logic [MW-2:0] abs_sat(input logic [MW-1:0] v);
        logic [MW-1:0] n;
        n = -v;
        if (!v[MW-1])              abs_sat = v[MW-2:0];
        else if (v[MW-2:0] == '0)  abs_sat = '1;
        else                       abs_sat = n[MW-2:0];
    endfunction

    function automatic logic [DW-1:0] sat(input logic [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = $signed(p) >>> GF;
        if (s > PMAX)      sat = {1'b0, {(DW-1){1'b1}}};
        else if (s < PMIN) sat = {1'b1, {(DW-1){1'b0}}};
        else               sat = s[DW-1:0];
    endfunction

    always_comb begin
        hi_d  = (a_q > b_q) ? a_q : b_q;
        lo_d  = (a_q > b_q) ? b_q : a_q;
        m_d   = {1'b0, hi_d} + MW'(lo_d >> 1);
        idx_d = (int'(m_d) > DEPTH - 1) ? AW'(DEPTH - 1) : AW'(m_d);
    end

    // Falling gain tracks quickly (ATK), rising gain slowly (REL); REL also sets the fraction bits.
    always_comb begin
        gtx_d = SW'(gt_q) << REL;
        gs_d  = gs_q;
        if (byp_q)              gs_d = GS_UNITY;
        else if (gtx_d < gs_q)  gs_d = gs_q - ((gs_q - gtx_d) >> ATK);
        else if (gtx_d > gs_q)  gs_d = gs_q + ((gtx_d - gs_q) >> REL);
    end

    // Entries are stored XOR unity so an all-zero power-up state reads back as unity gain.
    always_ff @(posedge clk_i) begin
        if (cwe_i) begin
            tbl_q[0] <= cin_i ^ UNITY;
            for (int k = 1; k < DEPTH; k++) tbl_q[k] <= tbl_q[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
            ov_q    <= 1'b0;
            ovr_q   <= 1'b0;
            dox_q   <= '0;
            doy_q   <= '0;
            gs_q    <= GS_UNITY;
        end else begin
            ov_q <= 1'b0;
            if (iv_i && !rdy_q) ovr_q <= 1'b1;
            case (state_q)
                S_IDLE: if (iv_i) begin
                    x_q     <= dix_i;
                    y_q     <= diy_i;
                    rdy_q   <= 1'b0;
                    state_q <= S_ABS;
                end
                S_ABS: begin
                    a_q     <= abs_sat(x_q[DW-1 -: MW]);
                    b_q     <= abs_sat(y_q[DW-1 -: MW]);
                    state_q <= S_MAG;
                end
                S_MAG: begin
                    idx_q   <= idx_d;
                    state_q <= S_LUT;
                end
                S_LUT: begin
                    gt_q    <= byp_i ? UNITY : (tbl_q[idx_q] ^ UNITY);
                    byp_q   <= byp_i;
                    state_q <= S_SMO;
                end
                S_SMO: begin
                    gs_q    <= gs_d;
                    gain_q  <= gs_d[SW-1:REL];
                    mx_q    <= {{(PW-DW){x_q[DW-1]}}, x_q};
                    my_q    <= {{(PW-DW){y_q[DW-1]}}, y_q};
                    ax_q    <= '0;
                    ay_q    <= '0;
                    cnt_q   <= '0;
                    state_q <= S_MUL;
                end
                S_MUL: begin
                    if (gain_q[0]) begin
                        ax_q <= ax_q + mx_q;
                        ay_q <= ay_q + my_q;
                    end
                    mx_q   <= mx_q << 1;
                    my_q   <= my_q << 1;
                    gain_q <= gain_q >> 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(GW - 1)) state_q <= S_OUT;
                end
                S_OUT: begin
                    dox_q   <= sat(ax_q);
                    doy_q   <= sat(ay_q);
                    ov_q    <= 1'b1;
                    rdy_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdy_o  = rdy_q;
    assign dox_o  = dox_q;
    assign doy_o  = doy_q;
    assign ov_o   = ov_q;
    assign ovr_o  = ovr_q;
    assign gmon_o = gs_q[SW-1:REL];
endmodule

// File: tb/tb_comp_agc_p.sv
// Bench for comp_agc_p: directed scenarios with literal expectations plus a random phase
// checked every cycle against a sample-level behavioural model.
module tb_comp_agc_p;
    localparam int DW = 16, MW = 8, AW = 7, GW = 8, GF = 4, ATK = 2, REL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, iv, cwe, byp, rdy, ov, ovr;
    logic [15:0] dix, diy, dox, doy;
    logic [7:0]  cin, gmon;

    comp_agc_p #(.DW(DW), .MW(MW), .AW(AW), .GW(GW), .GF(GF), .ATK(ATK), .REL(REL)) dut (
        .clk_i(clk), .rst_i(rst), .dix_i(dix), .diy_i(diy), .iv_i(iv), .rdy_o(rdy),
        .dox_o(dox), .doy_o(doy), .ov_o(ov), .cin_i(cin), .cwe_i(cwe), .byp_i(byp),
        .gmon_o(gmon), .ovr_o(ovr)
    );

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (per-sample arithmetic, timed by clocks since acceptance)
    int m_ph = -1, m_gs = 16 << REL, m_x, m_y, m_gt, m_dox = 0, m_doy = 0;
    bit m_ov = 0, m_ovr = 0, m_byp;
    int m_tbl [128];
    initial for (int k = 0; k < 128; k++) m_tbl[k] = 16;

    function automatic int mag_abs(input int v);
        int t;
        t = v >>> 8;
        if (t == -128) return 127;
        return (t < 0) ? -t : t;
    endfunction

    function automatic int satv(input int p);
        if (p > 32767)  return 32767;
        if (p < -32768) return -32768;
        return p;
    endfunction

    always @(posedge clk) begin
        bit busy;
        int a, b, m, idx, gtx;
        busy = (m_ph >= 0);
        if (rst) begin
            m_ph = -1; m_gs = 16 << REL; m_ovr = 0; m_ov = 0; m_dox = 0; m_doy = 0;
        end else begin
            if (busy && iv) m_ovr = 1;
            m_ov = 0;
            if (busy) begin
                m_ph++;
                if (m_ph == 3) begin
                    a = mag_abs(m_x); b = mag_abs(m_y);
                    m = (a > b) ? a + (b >> 1) : b + (a >> 1);
                    idx = (m > 127) ? 127 : m;
                    m_byp = byp;
                    m_gt = byp ? 16 : m_tbl[idx];
                end else if (m_ph == 4) begin
                    gtx = m_gt << REL;
                    if (m_byp)           m_gs = 16 << REL;
                    else if (gtx < m_gs) m_gs = m_gs - ((m_gs - gtx) >> ATK);
                    else if (gtx > m_gs) m_gs = m_gs + ((gtx - m_gs) >> REL);
                end else if (m_ph == 13) begin
                    m_dox = satv((m_x * (m_gs >> REL)) >>> GF);
                    m_doy = satv((m_y * (m_gs >> REL)) >>> GF);
                    m_ov = 1;
                    m_ph = -1;
                end
            end else if (iv) begin
                m_x = int'($signed(dix));
                m_y = int'($signed(diy));
                m_ph = 0;
            end
        end
        if (cwe) begin
            for (int k = 127; k > 0; k--) m_tbl[k] = m_tbl[k-1];
            m_tbl[0] = int'(cin);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ov", int'(ov), int'(m_ov));
            check("rdy", int'(rdy), int'(m_ph < 0));
            check("ovr", int'(ovr), int'(m_ovr));
            check("gmon", int'(gmon), m_gs >> REL);
            check("dox", int'(dox), m_dox & 'hFFFF);
            check("doy", int'(doy), m_doy & 'hFFFF);
        end
    end

    // ---------------- stimulus helpers
    task automatic do_reset();
        @(negedge clk); rst = 1; iv = 0; cwe = 0;
        @(negedge clk); rst = 0;
    endtask

    // mode 0: all entries c; mode 1: tbl[k]=k; mode 2: random
    task automatic load(input int mode, input int c);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            cwe = 1;
            cin = (mode == 0) ? 8'(c) : (mode == 1) ? 8'(127 - i) : 8'($urandom);
        end
        @(negedge clk); cwe = 0;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk); dix = x; diy = y; iv = 1;
        @(posedge clk); #1; iv = 0;
    endtask

    task automatic wait_ov(output int lat, output int low);
        lat = -1; low = 0;
        for (int i = 0; i < 40; i++) begin
            if (ov) begin lat = i; break; end
            if (!rdy) low++;
            @(posedge clk); #1;
        end
        if (lat < 0) check("ov_timeout", 0, 1);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom % 6)
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'(($urandom % 64) - 32);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int lat, low, prev, cnt;
        rst = 1; iv = 0; cwe = 0; byp = 0; dix = 0; diy = 0; cin = 0;
        @(posedge clk);
        @(negedge clk); chk_en = 1;
        @(negedge clk); rst = 0;
        check("rst_gmon", int'(gmon), 16);
        check("rst_dox", int'(dox), 0);
        check("rst_rdy", int'(rdy), 1);
        check("rst_ov", int'(ov), 0);

        // unity table passes data through; latency and busy window
        load(0, 8'h10);
        send(16'h4000, 16'hC000);
        wait_ov(lat, low);
        check("t1_lat", lat, 13);
        check("t1_rdy_low", low, 13);
        check("t1_dox", int'(dox), 'h4000);
        check("t1_doy", int'(doy), 'hC000);

        // attack: gain 8 approached from unity
        do_reset();
        load(0, 8'h08);
        send(16'h1000, 16'h0000);
        wait_ov(lat, low);
        check("t2_gmon", int'(gmon), 14);
        check("t2_dox", int'(dox), 'h0E00);
        prev = int'(gmon);
        for (int i = 0; i < 40; i++) begin
            send(16'h1000, 16'h0000);
            wait_ov(lat, low);
            check("t2_mono", int'(int'(gmon) <= prev), 1);
            prev = int'(gmon);
        end
        check("t2_gmon_final", int'(gmon), 8);
        check("t2_dox_final", int'(dox), 'h0800);

        // reset in the middle of the multiply
        send(16'h1000, 16'h0000);
        repeat (7) @(posedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        check("t6_rdy", int'(rdy), 1);
        check("t6_dox", int'(dox), 0);
        check("t6_gmon", int'(gmon), 16);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (ov) cnt++; end
        check("t6_no_ov", cnt, 0);
        send(16'h1000, 16'h0000);
        wait_ov(lat, low);
        check("t6_tbl_kept", int'(dox), 'h0E00);

        // overrun during a busy sample
        send(16'h1000, 16'h0000);
        repeat (6) @(posedge clk);
        @(negedge clk); iv = 1; dix = 16'h2222;
        @(negedge clk); iv = 0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (ov) cnt++; end
        check("t5_single_ov", cnt, 1);
        check("t5_ovr", int'(ovr), 1);
        do_reset();
        check("t5_ovr_clr", int'(ovr), 0);

        // release toward a high gain until saturation
        load(0, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            send(16'h7000, 16'h0001);
            wait_ov(lat, low);
        end
        check("t3_pos_sat", int'(dox), 'h7FFF);
        check("t3_small", int'(doy), 'h0001);
        send(16'h8000, 16'h0001);
        wait_ov(lat, low);
        check("t3_neg_sat", int'(dox), 'h8000);
        check("t3_gmon", int'(gmon), 20);

        // ramp table and bypass
        do_reset();
        load(1, 0);
        byp = 1;
        send(16'h7FFF, 16'h7FFF);
        wait_ov(lat, low);
        check("t4_byp_x", int'(dox), 'h7FFF);
        check("t4_byp_y", int'(doy), 'h7FFF);
        send(16'h8123, 16'h1234);
        wait_ov(lat, low);
        check("t4_byp_x2", int'(dox), 'h8123);
        check("t4_byp_y2", int'(doy), 'h1234);
        byp = 0;

        // random traffic, table writes, bypass and occasional resets
        do_reset();
        load(2, 0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom % 400 == 0);
            iv  = ($urandom % 3 == 0);
            dix = pick();
            diy = pick();
            byp = ($urandom % 8 == 0);
            cwe = !rst && ($urandom % 12 == 0);
            cin = 8'($urandom);
        end
        @(negedge clk); rst = 0; iv = 0; cwe = 0; byp = 0;
        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
